point_mult: RTL
===============

POINT_MULT -- requirements
Module: point_mult

Interface
REQ-001 Clk  input  1  system clock; all logic on posedge Clk.
REQ-002 Reset  input  1  synchronous, active-high reset.
REQ-003 Start  input  1  one-cycle request; sampled only in IDLE.
REQ-004 k  input  256  scalar, unsigned; sampled on accepted Start.
REQ-005 Px, Py  input  256 each  affine base point on secp256k1; sampled on accepted Start.
REQ-006 Rx, Ry  output  256 each  affine result k*P; valid when Done=1, held until next accepted Start.
REQ-007 Inf  output  1  result is point at infinity (k=0); valid with Done.
REQ-008 Busy  output  1  high from accepted Start until the Done cycle, inclusive.
REQ-009 Done  output  1  one-cycle pulse marking result valid.

Function
REQ-010 The block SHALL compute k*P by left-to-right double-and-add, using one point_double and one point_add instance.
REQ-011 Group-op launch SHALL be: drive the unit's Reset high for exactly one cycle with operands stable, then low; the result is captured on the cycle its Done is first high.
REQ-012 States SHALL be IDLE, SCAN, DBL_GO, DBL_WAIT, ADD_GO, ADD_WAIT, FIN.
REQ-013 IDLE: Start=1 latches k, Px, Py; clears Inf; sets Busy; goes to SCAN with bit index i=255 (8-bit counter).
REQ-014 IDLE, latched k==0: go to FIN with Inf=1, Rx=Ry=0; Done SHALL be 2 cycles after Start.
REQ-015 SCAN: one bit per cycle; while k[i]==0, decrement i; at first k[i]==1, load R=P (no infinity arithmetic); if i==0 go to FIN, else decrement i and go to DBL_GO.
REQ-016 DBL_GO/DBL_WAIT: R=2R; then if k[i]==1 go to ADD_GO, else to the next-bit step.
REQ-017 ADD_GO/ADD_WAIT: R=R+P.
REQ-018 Next-bit step: if i==0 go to FIN, else decrement i, go to DBL_GO.
REQ-019 FIN: drive Rx,Ry from R, pulse Done for one cycle, drop Busy next cycle, return to IDLE.
REQ-020 Start while Busy SHALL be ignored, with no effect on state or latched operands.
REQ-021 Supported scalars: 0 <= k < n (group order); for k >= n, output is unspecified but Done SHALL still be produced.
REQ-022 All field arithmetic SHALL be mod p = 2^256 - 2^32 - 977, inherited from the sub-units.
REQ-023 Operation count SHALL be exactly (bitlen(k)-1) doublings plus (popcount(k)-1) additions.

Reset
REQ-024 Reset SHALL force IDLE, Rx=Ry=0, Inf=0, Busy=0, Done=0, i=255.
REQ-025 Reset mid-operation SHALL abort within one cycle, produce no Done, and hold both sub-units in reset.
REQ-026 After reset release, the block SHALL accept Start on the next cycle.

Structure
REQ-027 Shared package ec_pkg SHALL hold: the modulus P_MOD, group order N_ORD, generator GX/GY constants, and the state enum.
REQ-028 Sub-modules SHALL be the existing point_double and point_add only; no new sub-module.
REQ-029 Operand muxing into the group-op units SHALL be registered; R SHALL be a single 512-bit register pair.

Verification
REQ-030 k=1, P=G (GX=79BE667E...16F81798, GY=483ADA77...FB10D4B8) -> Done, R=G, Inf=0, zero group ops.
REQ-031 k=2, P=G -> Rx=C6047F9441ED7D6D3045406E95C07CD85C778E4B8CEF3CA7ABAC09B95C709EE5, Ry=1AE168FEA63DC339A3C58419466CEAEEF7F632653266D0E1236431A950CFE52A; 1 double, 0 adds.
REQ-032 k=3, P=G -> Rx=F9308A019258C31049344F85F89D5229B531C845836F99B08601F113BCE036F9, Ry=388F7B0F632DE8140FE337E62A37F3566500A99934C2231B6CB9FD7584B8E672; 1 double, 1 add.
REQ-033 k=0 -> Done 2 cycles after Start, Inf=1, Rx=Ry=0.
REQ-034 k=3 with a second Start (k=2) during DBL_WAIT -> second Start ignored; result equals 3G.
REQ-035 Reset asserted during ADD_WAIT -> no Done, all outputs 0; new Start k=2 -> 2G.

Source files
------------

// File: rtl/ec_pkg.sv
// Shared secp256k1 definitions for the scalar-multiply block and its group-op units.
// Holds the curve constants, the top-level state enum and the field helpers
// (mod-p add/sub/mul/halve, plus a one-step binary extended-Euclid inverter).
package ec_pkg;

  localparam logic [255:0] P_MOD = 256'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEFFFFFC2F;
  localparam logic [255:0] N_ORD = 256'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEBAAEDCE6AF48A03BBFD25E8CD0364141;
  localparam logic [255:0] GX    = 256'h79BE667EF9DCBBAC55A06295CE870B07029BFCDB2DCE28D959F2815B16F81798;
  localparam logic [255:0] GY    = 256'h483ADA7726A3C4655DA4FBFC0E1108A8FD17B448A68554199C47D08FFB10D4B8;
  // 2^256 mod p, used to fold the high half of a product back in.
  localparam logic [32:0]  RC    = 33'h1000003D1;

  typedef enum logic [2:0] {IDLE, SCAN, DBL_GO, DBL_WAIT, ADD_GO, ADD_WAIT, FIN} pm_state_t;

  // Inverter state: invariants x1*a == u and x2*a == v (mod p).
  typedef struct packed {
    logic [255:0] u;
    logic [255:0] v;
    logic [255:0] x1;
    logic [255:0] x2;
  } inv_t;

  function automatic logic [255:0] fred(input logic [511:0] x);
    logic [289:0] t;
    logic [256:0] s;
    t = 290'(x[511:256]) * 290'(RC) + 290'(x[255:0]);
    s = 257'(t[289:256]) * 257'(RC) + 257'(t[255:0]);
    // After two folds the value is below 2^256 + 2^67, so one subtract suffices.
    if (s >= {1'b0, P_MOD}) s = s - {1'b0, P_MOD};
    return s[255:0];
  endfunction

  function automatic logic [255:0] fmul(input logic [255:0] a, input logic [255:0] b);
    return fred({256'd0, a} * {256'd0, b});
  endfunction

  function automatic logic [255:0] fadd(input logic [255:0] a, input logic [255:0] b);
    logic [256:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, P_MOD}) s = s - {1'b0, P_MOD};
    return s[255:0];
  endfunction

  // Wraps mod 2^256 when a < b; the true result is below p so the wrap is exact.
  function automatic logic [255:0] fsub(input logic [255:0] a, input logic [255:0] b);
    return (a >= b) ? (a - b) : (a - b + P_MOD);
  endfunction

  function automatic logic [255:0] fhalf(input logic [255:0] a);
    logic [256:0] t;
    t = a[0] ? ({1'b0, a} + {1'b0, P_MOD}) : {1'b0, a};
    return t[256:1];
  endfunction

  function automatic inv_t inv_init(input logic [255:0] a);
    inv_t s;
    s.u  = a;
    s.v  = P_MOD;
    s.x1 = 256'd1;
    s.x2 = 256'd0;
    return s;
  endfunction

  // u==0 only for a zero operand (never reached for valid k); it stops the loop.
  function automatic logic inv_done(input inv_t s);
    return (s.u == 256'd1) || (s.v == 256'd1) || (s.u == 256'd0);
  endfunction

  function automatic logic [255:0] inv_res(input inv_t s);
    return (s.u == 256'd1) ? s.x1 : s.x2;
  endfunction

  function automatic inv_t inv_step(input inv_t s);
    inv_t n;
    n = s;
    if (!s.u[0]) begin
      n.u  = s.u >> 1;
      n.x1 = fhalf(s.x1);
    end else if (!s.v[0]) begin
      n.v  = s.v >> 1;
      n.x2 = fhalf(s.x2);
    end else if (s.u >= s.v) begin
      n.u  = s.u - s.v;
      n.x1 = fsub(s.x1, s.x2);
    end else begin
      n.v  = s.v - s.u;
      n.x2 = fsub(s.x2, s.x1);
    end
    return n;
  endfunction

endpackage

// File: rtl/point_add.sv
// Affine point addition R = (X1,Y1) + (X2,Y2) on secp256k1, X1 != X2.
// Launch: hold Reset high one cycle with operands stable; Done rises with Rx,Ry
// valid and stays high until the next Reset.
// Ports: Clk, Reset (sync, high = launch/clear), X1,Y1,X2,Y2 in; Rx,Ry,Done out.
module point_add
  import ec_pkg::*;
(
  input  logic         Clk,
  input  logic         Reset,
  input  logic [255:0] X1,
  input  logic [255:0] Y1,
  input  logic [255:0] X2,
  input  logic [255:0] Y2,
  output logic [255:0] Rx,
  output logic [255:0] Ry,
  output logic         Done
);

  typedef enum logic [1:0] {PA_INV, PA_XO, PA_YO, PA_DONE} pa_state_t;

  pa_state_t    st, st_d;
  inv_t         iv;
  logic [255:0] x1r, y1r, x2r, num, lam;
  logic         inv_fin;

  assign inv_fin = inv_done(iv);

  always_comb begin
    st_d = st;
    case (st)
      PA_INV:  if (inv_fin) st_d = PA_XO;
      PA_XO:   st_d = PA_YO;
      PA_YO:   st_d = PA_DONE;
      default: st_d = st;
    endcase
  end

  // lambda = (y2-y1)/(x2-x1); x3 = lambda^2 - x1 - x2; y3 = lambda(x1 - x3) - y1
  always_ff @(posedge Clk) begin
    if (Reset) begin
      st   <= PA_INV;
      iv   <= inv_init(fsub(X2, X1));
      num  <= fsub(Y2, Y1);
      x1r  <= X1;
      y1r  <= Y1;
      x2r  <= X2;
      lam  <= '0;
      Rx   <= '0;
      Ry   <= '0;
      Done <= 1'b0;
    end else begin
      st <= st_d;
      case (st)
        PA_INV: if (inv_fin) lam <= fmul(num, inv_res(iv));
                else         iv  <= inv_step(iv);
        PA_XO:  Rx <= fsub(fsub(fmul(lam, lam), x1r), x2r);
        PA_YO:  begin
          Ry   <= fsub(fmul(lam, fsub(x1r, Rx)), y1r);
          Done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/point_double.sv
// Affine point doubling R = 2(X,Y) on secp256k1.
// Launch: hold Reset high one cycle with X,Y stable; Done rises with Rx,Ry valid
// and stays high until the next Reset.
// Ports: Clk, Reset (sync, high = launch/clear), X,Y in; Rx,Ry,Done out.
module point_double
  import ec_pkg::*;
(
  input  logic         Clk,
  input  logic         Reset,
  input  logic [255:0] X,
  input  logic [255:0] Y,
  output logic [255:0] Rx,
  output logic [255:0] Ry,
  output logic         Done
);

  typedef enum logic [1:0] {PD_INV, PD_XO, PD_YO, PD_DONE} pd_state_t;

  pd_state_t    st, st_d;
  inv_t         iv;
  logic [255:0] xr, yr, num, lam, x_sq;
  logic         inv_fin;

  assign x_sq    = fmul(X, X);
  assign inv_fin = inv_done(iv);

  always_comb begin
    st_d = st;
    case (st)
      PD_INV:  if (inv_fin) st_d = PD_XO;
      PD_XO:   st_d = PD_YO;
      PD_YO:   st_d = PD_DONE;
      default: st_d = st;
    endcase
  end

  // lambda = 3x^2 / 2y; x3 = lambda^2 - 2x; y3 = lambda(x - x3) - y
  always_ff @(posedge Clk) begin
    if (Reset) begin
      st   <= PD_INV;
      iv   <= inv_init(fadd(Y, Y));
      num  <= fadd(fadd(x_sq, x_sq), x_sq);
      xr   <= X;
      yr   <= Y;
      lam  <= '0;
      Rx   <= '0;
      Ry   <= '0;
      Done <= 1'b0;
    end else begin
      st <= st_d;
      case (st)
        PD_INV: if (inv_fin) lam <= fmul(num, inv_res(iv));
                else         iv  <= inv_step(iv);
        PD_XO:  Rx <= fsub(fsub(fmul(lam, lam), xr), xr);
        PD_YO:  begin
          Ry   <= fsub(fmul(lam, fsub(xr, Rx)), yr);
          Done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/point_mult.sv
// Scalar multiplication k*P on secp256k1, left-to-right double-and-add.
// Leading zero bits are skipped one per cycle; the first set bit loads R=P so
// no infinity arithmetic is needed. k==0 short-cuts to an Inf result.
// Ports: Clk, Reset (sync, high), Start, k, Px, Py in;
//        Rx, Ry, Inf, Busy, Done (one-cycle pulse) out.
module point_mult
  import ec_pkg::*;
(
  input  logic         Clk,
  input  logic         Reset,
  input  logic         Start,
  input  logic [255:0] k,
  input  logic [255:0] Px,
  input  logic [255:0] Py,
  output logic [255:0] Rx,
  output logic [255:0] Ry,
  output logic         Inf,
  output logic         Busy,
  output logic         Done
);

  pm_state_t    state, state_d;
  logic [255:0] k_q, px_q, py_q, rx_q, ry_q;
  logic [255:0] dbl_x, dbl_y, add_x, add_y;
  logic [7:0]   idx;
  logic         bit_i, idx_dec;
  logic         dbl_start, add_start, dbl_done, add_done;

  assign bit_i     = k_q[idx];
  assign dbl_start = (state == DBL_GO);
  assign add_start = (state == ADD_GO);

  always_comb begin
    state_d = state;
    case (state)
      IDLE:     if (Start) state_d = (k == '0) ? FIN : SCAN;
      SCAN:     if (bit_i) state_d = (idx == 8'd0) ? FIN : DBL_GO;
      DBL_GO:   state_d = DBL_WAIT;
      DBL_WAIT: if (dbl_done) state_d = bit_i ? ADD_GO : ((idx == 8'd0) ? FIN : DBL_GO);
      ADD_GO:   state_d = ADD_WAIT;
      ADD_WAIT: if (add_done) state_d = (idx == 8'd0) ? FIN : DBL_GO;
      FIN:      state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Index moves down on every skipped leading zero and on each entry to DBL_GO.
  assign idx_dec = ((state == SCAN) && !bit_i) || (state_d == DBL_GO);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
      idx   <= 8'd255;
      k_q   <= '0;
      px_q  <= '0;
      py_q  <= '0;
      rx_q  <= '0;
      ry_q  <= '0;
      Rx    <= '0;
      Ry    <= '0;
      Inf   <= 1'b0;
      Busy  <= 1'b0;
      Done  <= 1'b0;
    end else begin
      state <= state_d;
      Done  <= 1'b0;
      if (idx_dec) idx <= idx - 8'd1;
      case (state)
        IDLE: begin
          if (Start) begin
            k_q  <= k;
            px_q <= Px;
            py_q <= Py;
            idx  <= 8'd255;
            Inf  <= 1'b0;
            Busy <= 1'b1;
          end else begin
            Busy <= 1'b0;
          end
        end
        SCAN: if (bit_i) begin
          rx_q <= px_q;
          ry_q <= py_q;
        end
        DBL_WAIT: if (dbl_done) begin
          rx_q <= dbl_x;
          ry_q <= dbl_y;
        end
        ADD_WAIT: if (add_done) begin
          rx_q <= add_x;
          ry_q <= add_y;
        end
        FIN: begin
          Done <= 1'b1;
          Inf  <= (k_q == '0);
          Rx   <= (k_q == '0) ? '0 : rx_q;
          Ry   <= (k_q == '0) ? '0 : ry_q;
        end
        default: ;
      endcase
    end
  end

  // Units sit in reset whenever the block does, and get a one-cycle launch
  // pulse from their GO state; operands come straight from the R/P registers.
  point_double u_dbl (
    .Clk   (Clk),
    .Reset (Reset | dbl_start),
    .X     (rx_q),
    .Y     (ry_q),
    .Rx    (dbl_x),
    .Ry    (dbl_y),
    .Done  (dbl_done)
  );

  point_add u_add (
    .Clk   (Clk),
    .Reset (Reset | add_start),
    .X1    (rx_q),
    .Y1    (ry_q),
    .X2    (px_q),
    .Y2    (py_q),
    .Rx    (add_x),
    .Ry    (add_y),
    .Done  (add_done)
  );

endmodule
